// File: rtl/usb_tx_bit_sequencer.sv
// USB full-speed transmit bit sequencer.
// Produces the per-bit tick from an internal bit-period counter. Sequences SYNC, data bytes,
// bit-stuff slots and EOP. Drives load/shift/stuff strobes to the TX shift register and the
// NRZI/stuff encoder, and pops bytes from the TX FIFO.
//
// Optional feature: define USB_TX_ABORT_EN to add the tx_abort_i input. When it is asserted
// in SYNC, DATA or TAIL, the packet is cut short: EOP starts at the next tick and the packet
// ends with tx_error_o.
//
// Ports:
//   clk, n_rst        system clock, asynchronous active-low reset
//   tx_start_i        request to begin a packet; honoured only in IDLE
//   byte_valid_i      FIFO has a byte available
//   byte_last_i       byte at the FIFO head is the final packet byte
//   stuff_req_i       the current bit slot must be a stuff bit
//   tx_abort_i        abort the packet in progress (USB_TX_ABORT_EN only)
//   load_sync_o       pulse: shift register loads SYNC (0x80)
//   byte_load_o       pulse: shift register loads the FIFO head and the FIFO pops
//   shift_strobe_o    pulse: shift out one data bit
//   stuff_strobe_o    pulse: encoder emits a stuff bit
//   drive_se0_o       level: line driver forces SE0
//   drive_j_o         level: line driver forces J
//   bit_index_o       index of the next data bit within the current byte
//   tx_busy_o         high whenever not idle
//   tx_done_o         pulse at packet end
//   tx_error_o        pulse with tx_done_o on underrun or abort
module usb_tx_bit_sequencer #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned CNT_BITS     = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start_i,
   input  logic       byte_valid_i,
   input  logic       byte_last_i,
   input  logic       stuff_req_i,
`ifdef USB_TX_ABORT_EN
   input  logic       tx_abort_i,
`endif
   output logic       load_sync_o,
   output logic       byte_load_o,
   output logic       shift_strobe_o,
   output logic       stuff_strobe_o,
   output logic       drive_se0_o,
   output logic       drive_j_o,
   output logic [2:0] bit_index_o,
   output logic       tx_busy_o,
   output logic       tx_done_o,
   output logic       tx_error_o
);

   typedef enum logic [2:0] {StIdle, StSync, StData, StTail, StEopSe0, StEopJ} state_e;

   localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(CLKS_PER_BIT);
   localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);

   state_e              state_q;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [2:0]          bit_idx_q;
   logic                last_q, err_q, tail_stuffed_q, se0_half_q;
   logic                load_sync_q, byte_load_q, shift_q, stuff_q;
   logic                drive_se0_q, drive_j_q, tx_busy_q, tx_done_q, tx_error_q;
   logic                tick, abort_hit;

   assign tick = (cnt_q == CntMax);

`ifdef USB_TX_ABORT_EN
   logic in_pkt, abort_q;

   assign in_pkt    = (state_q == StSync) || (state_q == StData) || (state_q == StTail);
   assign abort_hit = in_pkt && (abort_q || tx_abort_i);

   // Holds an abort request raised between ticks until the tick that acts on it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         abort_q <= 1'b0;
      end else begin
         abort_q <= in_pkt && !tick && (abort_q || tx_abort_i);
      end
   end
`else
   assign abort_hit = 1'b0;
`endif

   // Cleared in IDLE, 1 in the first cycle after leaving IDLE, then 1..CLKS_PER_BIT.
   always_comb begin
      cnt_d = cnt_q + CntOne;
      if (state_q == StIdle) begin
         cnt_d = tx_start_i ? CntOne : '0;
      end else if (tick) begin
         cnt_d = (state_q == StEopJ) ? '0 : CntOne;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         bit_idx_q      <= 3'd0;
         last_q         <= 1'b0;
         err_q          <= 1'b0;
         tail_stuffed_q <= 1'b0;
         se0_half_q     <= 1'b0;
         load_sync_q    <= 1'b0;
         byte_load_q    <= 1'b0;
         shift_q        <= 1'b0;
         stuff_q        <= 1'b0;
         drive_se0_q    <= 1'b0;
         drive_j_q      <= 1'b0;
         tx_busy_q      <= 1'b0;
         tx_done_q      <= 1'b0;
         tx_error_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         load_sync_q <= 1'b0;
         byte_load_q <= 1'b0;
         shift_q     <= 1'b0;
         stuff_q     <= 1'b0;
         tx_done_q   <= 1'b0;
         tx_error_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tx_start_i) begin
                  load_sync_q    <= 1'b1;
                  tx_busy_q      <= 1'b1;
                  bit_idx_q      <= 3'd0;
                  last_q         <= 1'b0;
                  err_q          <= 1'b0;
                  tail_stuffed_q <= 1'b0;
                  se0_half_q     <= 1'b0;
                  state_q        <= StSync;
               end
            end
            StSync, StData: begin
               if (tick) begin
                  if (abort_hit) begin
                     err_q       <= 1'b1;
                     drive_se0_q <= 1'b1;
                     state_q     <= StEopSe0;
                  end else if (state_q == StData && stuff_req_i) begin
                     stuff_q <= 1'b1;
                  end else begin
                     shift_q   <= 1'b1;
                     bit_idx_q <= bit_idx_q + 3'd1;
                     if (bit_idx_q == 3'd7) begin
                        // Byte boundary: the only point where byte_valid_i is sampled.
                        if (state_q == StData && last_q) begin
                           state_q <= StTail;
                        end else if (byte_valid_i) begin
                           byte_load_q <= 1'b1;
                           last_q      <= byte_last_i;
                           state_q     <= StData;
                        end else begin
                           err_q       <= 1'b1;
                           drive_se0_q <= 1'b1;
                           state_q     <= StEopSe0;
                        end
                     end
                  end
               end
            end
            StTail: begin
               if (tick) begin
                  if (!abort_hit && stuff_req_i && !tail_stuffed_q) begin
                     stuff_q        <= 1'b1;
                     tail_stuffed_q <= 1'b1;
                  end else begin
                     err_q       <= err_q | abort_hit;
                     drive_se0_q <= 1'b1;
                     state_q     <= StEopSe0;
                  end
               end
            end
            StEopSe0: begin
               if (tick) begin
                  if (se0_half_q) begin
                     se0_half_q  <= 1'b0;
                     drive_se0_q <= 1'b0;
                     drive_j_q   <= 1'b1;
                     state_q     <= StEopJ;
                  end else begin
                     se0_half_q <= 1'b1;
                  end
               end
            end
            StEopJ: begin
               if (tick) begin
                  drive_j_q  <= 1'b0;
                  tx_busy_q  <= 1'b0;
                  tx_done_q  <= 1'b1;
                  tx_error_q <= err_q;
                  err_q      <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign load_sync_o    = load_sync_q;
   assign byte_load_o    = byte_load_q;
   assign shift_strobe_o = shift_q;
   assign stuff_strobe_o = stuff_q;
   assign drive_se0_o    = drive_se0_q;
   assign drive_j_o      = drive_j_q;
   assign bit_index_o    = bit_idx_q;
   assign tx_busy_o      = tx_busy_q;
   assign tx_done_o      = tx_done_q;
   assign tx_error_o     = tx_error_q;

endmodule

// File: tb/tb_usb_tx_bit_sequencer.sv
// Directed bench for usb_tx_bit_sequencer (CLKS_PER_BIT = 8).
// Iteration c of a packet run drives the inputs sampled at clock edge c (edge 0 accepts
// tx_start) and samples the outputs produced by edge c-1. Tick k is sampled at edge 8k, so
// its strobe is seen at iteration 8k+1.
module tb_usb_tx_bit_sequencer;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_start = 1'b0, byte_valid = 1'b0, byte_last = 1'b0, stuff_req = 1'b0;
   logic       tx_abort = 1'b0;
   logic       load_sync, byte_load, shift_strobe, stuff_strobe, drive_se0, drive_j;
   logic [2:0] bit_index;
   logic       tx_busy, tx_done, tx_error;

   int checks = 0;
   int errors = 0;

   usb_tx_bit_sequencer #(.CLKS_PER_BIT(8), .CNT_BITS(4)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .tx_start_i    (tx_start),
      .byte_valid_i  (byte_valid),
      .byte_last_i   (byte_last),
      .stuff_req_i   (stuff_req),
`ifdef USB_TX_ABORT_EN
      .tx_abort_i    (tx_abort),
`endif
      .load_sync_o   (load_sync),
      .byte_load_o   (byte_load),
      .shift_strobe_o(shift_strobe),
      .stuff_strobe_o(stuff_strobe),
      .drive_se0_o   (drive_se0),
      .drive_j_o     (drive_j),
      .bit_index_o   (bit_index),
      .tx_busy_o     (tx_busy),
      .tx_done_o     (tx_done),
      .tx_error_o    (tx_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    nbytes;      // bytes the FIFO model offers
      bit    last_ok;     // mark the final offered byte with byte_last
      int    sf, st;      // stuff_req held from tick sf to tick st (0 = never)
      int    abort_tick;  // tx_abort pulsed just before this tick (0 = never)
      int    exp_shift, exp_stuff, exp_loads, exp_load_last, exp_stuff_idx, exp_done, exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] outs();
      return {load_sync, byte_load, shift_strobe, stuff_strobe, drive_se0, drive_j,
              bit_index, tx_busy, tx_done, tx_error};
   endfunction

   task automatic run_vec(input vec_t v);
      int n_ls = 0, ls_iter = 0, first_sh = 0, n_sh = 0, n_st = 0, st_idx = -1;
      int n_bl = 0, bl_last = 0, n_se0 = 0, n_j = 0, n_done = 0, done_iter = 0;
      int err_at_done = -1, busy_cnt = 0, stray_err = 0, loads_seen = 0;
      for (int c = 0; c < v.exp_done + 12; c++) begin
         @(negedge clk);
         if (load_sync) begin n_ls++; if (ls_iter == 0) ls_iter = c; end
         if (shift_strobe) begin n_sh++; if (first_sh == 0) first_sh = c; end
         if (stuff_strobe) begin n_st++; st_idx = int'(bit_index); end
         if (byte_load) begin n_bl++; bl_last = c; loads_seen++; end
         if (drive_se0) n_se0++;
         if (drive_j) n_j++;
         if (tx_busy) busy_cnt++;
         if (tx_done) begin n_done++; done_iter = c; err_at_done = int'(tx_error); end
         if (tx_error && !tx_done) stray_err++;
         // Second tx_start lands while busy and must be ignored.
         tx_start   = (c == 0) || (c == 40);
         byte_valid = (loads_seen < v.nbytes);
         byte_last  = v.last_ok && (loads_seen == v.nbytes - 1);
         stuff_req  = (v.sf != 0) && (c >= 8 * v.sf) && (c <= 8 * v.st);
         tx_abort   = (v.abort_tick != 0) && (c == 8 * v.abort_tick - 2);
      end
      tx_start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; stuff_req = 1'b0; tx_abort = 1'b0;
      chk({v.name, " load_sync count"}, n_ls, 1);
      chk({v.name, " load_sync time"}, ls_iter, 1);
      chk({v.name, " first shift time"}, first_sh, 9);
      chk({v.name, " shifts"}, n_sh, v.exp_shift);
      chk({v.name, " stuffs"}, n_st, v.exp_stuff);
      chk({v.name, " stuff bit_index"}, st_idx, v.exp_stuff_idx);
      chk({v.name, " byte_loads"}, n_bl, v.exp_loads);
      chk({v.name, " last byte_load time"}, bl_last, v.exp_load_last);
      chk({v.name, " se0 clocks"}, n_se0, 16);
      chk({v.name, " j clocks"}, n_j, 8);
      chk({v.name, " tx_done count"}, n_done, 1);
      chk({v.name, " tx_done time"}, done_iter, v.exp_done);
      chk({v.name, " tx_error at done"}, err_at_done, v.exp_err);
      chk({v.name, " stray tx_error"}, stray_err, 0);
      chk({v.name, " busy clocks"}, busy_cnt, v.exp_done - 1);
   endtask

   initial begin
      //           name          nb last sf  st  ab shf stf lds lastld idx done err
      vecs.push_back('{"one_byte",   1, 1, 0,  0,  0, 16, 0, 1,  65, -1, 161, 0});
      vecs.push_back('{"data_stuff", 2, 1, 15, 15, 0, 24, 1, 2, 137,  6, 233, 0});
      vecs.push_back('{"tail_stuff", 1, 1, 17, 17, 0, 16, 1, 1,  65,  0, 169, 0});
      vecs.push_back('{"tail_stuf2", 1, 1, 17, 18, 0, 16, 1, 1,  65,  0, 169, 0});
      vecs.push_back('{"sync_under", 0, 0, 0,  0,  0,  8, 0, 0,   0, -1,  89, 1});
      vecs.push_back('{"data_under", 1, 0, 0,  0,  0, 16, 0, 1,  65, -1, 153, 1});
      vecs.push_back('{"sync_stuff", 1, 1, 3,  5,  0, 16, 0, 1,  65, -1, 161, 0});
`ifdef USB_TX_ABORT_EN
      vecs.push_back('{"abort_d3",   2, 1, 0,  0, 12, 11, 0, 1,  65, -1, 121, 1});
`endif

      // Reset held with random inputs: every output stays 0.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tx_start   = 1'($urandom);
         byte_valid = 1'($urandom);
         byte_last  = 1'($urandom);
         stuff_req  = 1'($urandom);
         tx_abort   = 1'($urandom);
         #1 chk("reset outputs", int'(outs()), 0);
      end
      @(negedge clk);
      tx_start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; stuff_req = 1'b0; tx_abort = 1'b0;
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle after release", int'(outs()), 0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset mid-packet: outputs clear at once and no tx_done follows.
      @(negedge clk);
      tx_start   = 1'b1;
      byte_valid = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (50) @(negedge clk);
      chk("busy before mid reset", int'(tx_busy), 1);
      #2 n_rst = 1'b0;
      #1 chk("mid reset outputs", int'(outs()), 0);
      @(negedge clk);
      n_rst = 1'b1;
      byte_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post reset idle", int'(outs()), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
